goal_score_keeper: RTL and testbench

Frame-based goal detector and score counter for the foosball game. It sits directly downstream of the background drawer and consumes its `teamGoalDrawReq` / `oppGoalDrawReq` back-of-goal pulses. Each frame it checks whether the ball pixel coincided with either goal line, then updates the scores. After a goal it holds a freeze window so the ball can be re-spawned, and it flags game-over when either side reaches the winning score.

---
 rtl/goal_score_keeper.sv | 195 +++++++++++++++++++
 tb/tb_goal_score_keeper.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goal_score_keeper.sv
// goal_score_keeper
//
// Purpose:
//   Frame-based goal detector and score counter for the foosball game.
//
//   While a frame is being drawn, the block records whether the ball pixel
//   ever coincided with either goal's back line. At the start of the next
//   frame it turns those records into a goal for one side and updates the
//   scores.
//
//   After a goal the game freezes for FREEZE_FRAMES frames so that the ball
//   can be re-spawned. When either side reaches WIN_SCORE the block stops
//   in GAME_OVER until newGame is requested.
//
// Parameters:
//   WIN_SCORE      score that ends the game (1..15)
//   FREEZE_FRAMES  frames frozen after a goal (1..255)
//
// Ports:
//   clk             pixel clock shared with the drawers
//   resetN          asynchronous reset, active-high despite the name
//   startOfFrame    one-cycle pulse at the start of each frame
//   ballDrawReq     ball is painted on the current pixel
//   teamGoalDrawReq pixel on the team goal back line (opponent scores)
//   oppGoalDrawReq  pixel on the opponent goal back line (team scores)
//   newGame         synchronous restart request
//   teamScore       team score, 0..WIN_SCORE
//   oppScore        opponent score, 0..WIN_SCORE
//   goalPulse       one-cycle pulse when a goal is registered
//   goalByTeam      scorer of the last goal (1 = team)
//   freeze          high in FREEZE or GAME_OVER; the ball is held meanwhile
//   gameOver        high in GAME_OVER
//   teamWins        winner while gameOver is high (1 = team)

module goal_score_keeper #(
    parameter int WIN_SCORE     = 5,
    parameter int FREEZE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       ballDrawReq,
    input  logic       teamGoalDrawReq,
    input  logic       oppGoalDrawReq,
    input  logic       newGame,
    output logic [3:0] teamScore,
    output logic [3:0] oppScore,
    output logic       goalPulse,
    output logic       goalByTeam,
    output logic       freeze,
    output logic       gameOver,
    output logic       teamWins
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [7:0] FRZ = 8'(FREEZE_FRAMES);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        FREEZE    = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t     state_q,      state_d;
    logic [7:0] frameCnt_q,   frameCnt_d;
    logic       hitTeam_q,    hitTeam_d;
    logic       hitOpp_q,     hitOpp_d;
    logic [3:0] teamScore_q,  teamScore_d;
    logic [3:0] oppScore_q,   oppScore_d;
    logic       goalPulse_q,  goalPulse_d;
    logic       goalByTeam_q, goalByTeam_d;
    logic       teamWins_q,   teamWins_d;
    logic       freeze_q;
    logic       gameOver_q;

    // Next-state logic.
    //
    // The hit flags are sticky within a frame. They are cleared by
    // startOfFrame, but a coincidence on that same cycle re-sets the flag,
    // because that pixel already belongs to the new frame.
    //
    // In PLAY, the flags evaluated on startOfFrame are the registered
    // values, i.e. the flags of the frame that has just finished.
    always_comb begin
        state_d      = state_q;
        frameCnt_d   = frameCnt_q;
        teamScore_d  = teamScore_q;
        oppScore_d   = oppScore_q;
        goalPulse_d  = 1'b0;
        goalByTeam_d = goalByTeam_q;
        teamWins_d   = teamWins_q;
        hitTeam_d    = (hitTeam_q & ~startOfFrame) | (ballDrawReq & teamGoalDrawReq);
        hitOpp_d     = (hitOpp_q  & ~startOfFrame) | (ballDrawReq & oppGoalDrawReq);

        if (newGame) begin
            state_d      = PLAY;
            frameCnt_d   = 8'd0;
            teamScore_d  = 4'd0;
            oppScore_d   = 4'd0;
            goalByTeam_d = 1'b0;
            teamWins_d   = 1'b0;
            hitTeam_d    = 1'b0;
            hitOpp_d     = 1'b0;
        end else if (startOfFrame) begin
            case (state_q)
                PLAY: begin
                    // A frame with hits on both goals is treated as a glitch
                    // and ignored.
                    if (hitOpp_q && !hitTeam_q) begin
                        teamScore_d  = teamScore_q + 4'd1;
                        goalPulse_d  = 1'b1;
                        goalByTeam_d = 1'b1;
                        if (teamScore_q + 4'd1 == WIN) begin
                            state_d    = GAME_OVER;
                            teamWins_d = 1'b1;
                        end else begin
                            state_d    = FREEZE;
                            frameCnt_d = FRZ;
                        end
                    end else if (hitTeam_q && !hitOpp_q) begin
                        oppScore_d   = oppScore_q + 4'd1;
                        goalPulse_d  = 1'b1;
                        goalByTeam_d = 1'b0;
                        if (oppScore_q + 4'd1 == WIN) begin
                            state_d    = GAME_OVER;
                            teamWins_d = 1'b0;
                        end else begin
                            state_d    = FREEZE;
                            frameCnt_d = FRZ;
                        end
                    end
                end
                FREEZE: begin
                    // The frame that ends on the releasing startOfFrame is
                    // still frozen. Its flags are dropped by the normal
                    // startOfFrame clear.
                    if (frameCnt_q == 8'd1) begin
                        state_d    = PLAY;
                        frameCnt_d = 8'd0;
                    end else begin
                        frameCnt_d = frameCnt_q - 8'd1;
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // State and output registers.
    //
    // freeze and gameOver are decoded from the next state so that they
    // change on the same edge as the state itself, without going through
    // combinational decode at the outputs.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q      <= PLAY;
            frameCnt_q   <= 8'd0;
            hitTeam_q    <= 1'b0;
            hitOpp_q     <= 1'b0;
            teamScore_q  <= 4'd0;
            oppScore_q   <= 4'd0;
            goalPulse_q  <= 1'b0;
            goalByTeam_q <= 1'b0;
            teamWins_q   <= 1'b0;
            freeze_q     <= 1'b0;
            gameOver_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frameCnt_q   <= frameCnt_d;
            hitTeam_q    <= hitTeam_d;
            hitOpp_q     <= hitOpp_d;
            teamScore_q  <= teamScore_d;
            oppScore_q   <= oppScore_d;
            goalPulse_q  <= goalPulse_d;
            goalByTeam_q <= goalByTeam_d;
            teamWins_q   <= teamWins_d;
            freeze_q     <= (state_d != PLAY);
            gameOver_q   <= (state_d == GAME_OVER);
        end
    end

    assign teamScore  = teamScore_q;
    assign oppScore   = oppScore_q;
    assign goalPulse  = goalPulse_q;
    assign goalByTeam = goalByTeam_q;
    assign freeze     = freeze_q;
    assign gameOver   = gameOver_q;
    assign teamWins   = teamWins_q;

endmodule

// File: tb/tb_goal_score_keeper.sv
// tb_goal_score_keeper
//
// Purpose:
//   Self-checking bench for goal_score_keeper.
//
//   Each applied cycle pushes the expected outputs of a behavioural game
//   model into a scoreboard queue. After the active edge, the entry is
//   popped and compared against the DUT outputs.
//
//   Scenario-level checks against constants are added at the key points of
//   each scenario.

module tb_goal_score_keeper;

    localparam int WIN  = 2;
    localparam int FRZ  = 60;
    localparam int FLEN = 8;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       ballDrawReq;
    logic       teamGoalDrawReq;
    logic       oppGoalDrawReq;
    logic       newGame;
    logic [3:0] teamScore;
    logic [3:0] oppScore;
    logic       goalPulse;
    logic       goalByTeam;
    logic       freeze;
    logic       gameOver;
    logic       teamWins;

    int vectors     = 0;
    int miscompares = 0;
    int pulseCount  = 0;
    int frzSofCount = 0;

    typedef struct {
        int team;
        int opp;
        int pulse;
        int byTeam;
        int frz;
        int over;
        int wins;
    } expT;

    expT sbQ[$];

    // Behavioural model of the game.
    // mMode: 0 = playing, 1 = frozen, 2 = game over.
    int mTeam, mOpp, mPulse, mByTeam, mWins, mMode, mFramesLeft;
    bit mHitT, mHitO;

    goal_score_keeper #(
        .WIN_SCORE    (WIN),
        .FREEZE_FRAMES(FRZ)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .ballDrawReq    (ballDrawReq),
        .teamGoalDrawReq(teamGoalDrawReq),
        .oppGoalDrawReq (oppGoalDrawReq),
        .newGame        (newGame),
        .teamScore      (teamScore),
        .oppScore       (oppScore),
        .goalPulse      (goalPulse),
        .goalByTeam     (goalByTeam),
        .freeze         (freeze),
        .gameOver       (gameOver),
        .teamWins       (teamWins)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mTeam       = 0;
        mOpp        = 0;
        mPulse      = 0;
        mByTeam     = 0;
        mWins       = 0;
        mMode       = 0;
        mFramesLeft = 0;
        mHitT       = 1'b0;
        mHitO       = 1'b0;
    endfunction

    // One clock cycle of the game rules.
    // Scoring looks at the flags gathered before this cycle. The
    // coincidence seen on this cycle is credited to the frame that is
    // current after it.
    function automatic void modelStep(input bit sof, input bit ball,
                                      input bit tg, input bit og, input bit ng);
        bit oldT = mHitT;
        bit oldO = mHitO;
        mPulse = 0;
        if (ng) begin
            modelReset();
            return;
        end
        if (sof) begin
            if (mMode == 0) begin
                if (oldO && !oldT) begin
                    mTeam++;
                    mPulse  = 1;
                    mByTeam = 1;
                    if (mTeam == WIN) begin
                        mMode = 2;
                        mWins = 1;
                    end else begin
                        mMode       = 1;
                        mFramesLeft = FRZ;
                    end
                end else if (oldT && !oldO) begin
                    mOpp++;
                    mPulse  = 1;
                    mByTeam = 0;
                    if (mOpp == WIN) begin
                        mMode = 2;
                        mWins = 0;
                    end else begin
                        mMode       = 1;
                        mFramesLeft = FRZ;
                    end
                end
            end else if (mMode == 1) begin
                mFramesLeft--;
                if (mFramesLeft == 0) mMode = 0;
            end
            mHitT = 1'b0;
            mHitO = 1'b0;
        end
        if (ball && tg) mHitT = 1'b1;
        if (ball && og) mHitO = 1'b1;
    endfunction

    // Applies one cycle of stimulus and pushes the model's expected outputs
    // for the following edge onto the scoreboard. After the edge, the entry
    // is popped and compared with the DUT.
    task automatic applyStimulus(input bit sof, input bit ball, input bit tg,
                                 input bit og, input bit ng);
        expT e;
        expT got;
        startOfFrame    = sof;
        ballDrawReq     = ball;
        teamGoalDrawReq = tg;
        oppGoalDrawReq  = og;
        newGame         = ng;
        if (sof && freeze === 1'b1) frzSofCount++;
        modelStep(sof, ball, tg, og, ng);
        e.team   = mTeam;
        e.opp    = mOpp;
        e.pulse  = mPulse;
        e.byTeam = mByTeam;
        e.frz    = (mMode != 0) ? 1 : 0;
        e.over   = (mMode == 2) ? 1 : 0;
        e.wins   = mWins;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput("sb.teamScore",  8'(teamScore),  8'(got.team));
        checkOutput("sb.oppScore",   8'(oppScore),   8'(got.opp));
        checkOutput("sb.goalPulse",  8'(goalPulse),  8'(got.pulse));
        checkOutput("sb.goalByTeam", 8'(goalByTeam), 8'(got.byTeam));
        checkOutput("sb.freeze",     8'(freeze),     8'(got.frz));
        checkOutput("sb.gameOver",   8'(gameOver),   8'(got.over));
        checkOutput("sb.teamWins",   8'(teamWins),   8'(got.wins));
        if (goalPulse === 1'b1) pulseCount++;
    endtask

    // One frame of FLEN cycles. Cycle 0 carries startOfFrame. The ball
    // coincides with the selected goal line(s) for hitLen cycles starting
    // at hitStart.
    task automatic runFrame(input int hitStart, input int hitLen,
                            input bit onTeam, input bit onOpp);
        for (int c = 0; c < FLEN; c++) begin
            bit h;
            h = (c >= hitStart) && (c < hitStart + hitLen);
            applyStimulus(c == 0, h, h & onTeam, h & onOpp, 1'b0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".teamScore"},  8'(teamScore),  8'd0);
        checkOutput({tag, ".oppScore"},   8'(oppScore),   8'd0);
        checkOutput({tag, ".goalPulse"},  8'(goalPulse),  8'd0);
        checkOutput({tag, ".goalByTeam"}, 8'(goalByTeam), 8'd0);
        checkOutput({tag, ".freeze"},     8'(freeze),     8'd0);
        checkOutput({tag, ".gameOver"},   8'(gameOver),   8'd0);
        checkOutput({tag, ".teamWins"},   8'(teamWins),   8'd0);
    endtask

    initial begin
        resetN          = 1'b1;
        startOfFrame    = 1'b0;
        ballDrawReq     = 1'b0;
        teamGoalDrawReq = 1'b0;
        oppGoalDrawReq  = 1'b0;
        newGame         = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        resetN = 1'b0;

        // Single team goal, then a 60-frame freeze. Hits during the freeze
        // are ignored; an opponent-side hit in the first play frame scores.
        runFrame(2, 3, 1'b0, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("goal1.teamScore",  8'(teamScore),  8'd1);
        checkOutput("goal1.goalByTeam", 8'(goalByTeam), 8'd1);
        checkOutput("goal1.freeze",     8'(freeze),     8'd1);
        frzSofCount = 0;
        for (int f = 1; f < FRZ; f++) begin
            runFrame(2, 3, f[0], ~f[0]);
        end
        runFrame(2, 2, 1'b1, 1'b0);
        checkOutput("goal1.freezeFrames", 8'(frzSofCount), 8'(FRZ));
        checkOutput("goal1.released",     8'(freeze),      8'd0);
        checkOutput("goal1.pulses",       8'(pulseCount),  8'd1);
        checkOutput("frz.teamScore",      8'(teamScore),   8'd1);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("opp1.oppScore",   8'(oppScore),   8'd1);
        checkOutput("opp1.goalByTeam", 8'(goalByTeam), 8'd0);
        checkOutput("opp1.freeze",     8'(freeze),     8'd1);
        for (int f = 0; f < FRZ; f++) begin
            runFrame(0, 0, 1'b0, 1'b0);
        end
        checkOutput("opp1.released", 8'(freeze), 8'd0);

        // A frame with hits on both goals is ignored.
        runFrame(1, 3, 1'b1, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("dbl.teamScore", 8'(teamScore),  8'd1);
        checkOutput("dbl.oppScore",  8'(oppScore),   8'd1);
        checkOutput("dbl.freeze",    8'(freeze),     8'd0);
        checkOutput("dbl.pulses",    8'(pulseCount), 8'd2);

        // A second team goal reaches WIN and ends the game.
        runFrame(2, 3, 1'b0, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("over.gameOver",  8'(gameOver),  8'd1);
        checkOutput("over.teamWins",  8'(teamWins),  8'd1);
        checkOutput("over.teamScore", 8'(teamScore), 8'd2);
        checkOutput("over.freeze",    8'(freeze),    8'd1);
        runFrame(2, 3, 1'b0, 1'b1);
        runFrame(2, 3, 1'b1, 1'b0);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("over.holdTeam", 8'(teamScore),  8'd2);
        checkOutput("over.holdOpp",  8'(oppScore),   8'd1);
        checkOutput("over.pulses",   8'(pulseCount), 8'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAllZero("newGame");

        // A coincidence on the startOfFrame cycle belongs to the new frame.
        runFrame(0, 1, 1'b0, 1'b1);
        checkOutput("edge.notYet", 8'(teamScore), 8'd0);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("edge.scored", 8'(teamScore), 8'd1);
        checkOutput("edge.freeze", 8'(freeze),    8'd1);

        // Reset asserted in the middle of the freeze clears everything at
        // once; play resumes normally afterwards.
        for (int f = 0; f < 5; f++) begin
            runFrame(0, 0, 1'b0, 1'b0);
        end
        #2;
        resetN = 1'b1;
        #1;
        checkAllZero("midRst");
        modelReset();
        startOfFrame    = 1'b0;
        ballDrawReq     = 1'b0;
        teamGoalDrawReq = 1'b0;
        oppGoalDrawReq  = 1'b0;
        newGame         = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b0;
        runFrame(2, 2, 1'b0, 1'b1);
        runFrame(0, 0, 1'b0, 1'b0);
        checkOutput("postRst.teamScore", 8'(teamScore), 8'd1);
        checkOutput("postRst.freeze",    8'(freeze),    8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
